// File: rtl/riptide_pkg.sv
// Shared RipTide types: sequencer state encoding and the PE cfg word width.
// Pure declarations, no logic and no latency.
// Backpressure is not applicable; this file only defines types and constants.
package riptide_pkg;

  localparam int RIPTIDE_CFG_WIDTH = 32;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_CLEAR,
    SEQ_LOAD,
    SEQ_RUN,
    SEQ_FIN,
    SEQ_ABORT
  } seq_state_t;

endpackage

// File: rtl/pe_array_seq_if.sv
// Host cfg word port: valid/ready handshake carrying one cfg word per beat.
// No latency of its own; this is a bundle of wires.
// The receiver throttles the host by holding host_ready low.
interface pe_array_seq_if #(
  parameter int CFG_WIDTH = riptide_pkg::RIPTIDE_CFG_WIDTH
);
  logic                 host_valid;
  logic [CFG_WIDTH-1:0] host_data;
  logic                 host_ready;

  modport master (output host_valid, output host_data, input host_ready);
  modport slave  (input host_valid, input host_data, output host_ready);
endinterface

// File: rtl/pe_array_seq.sv
// Sequencer for a PE column: clear, stream cfg words into the daisy chain, run, report.
// start->ctrl_clear 1 cycle; host word->cfg_out same cycle; last done->run_done 1 cycle.
// host_ready is high only in LOAD; on stall cycles cfg_en and cfg_out stay 0.
// Optional watchdog: define RIPTIDE_SEQ_TIMEOUT_EN to bound RUN and flag err on expiry.
module pe_array_seq
  import riptide_pkg::*;
#(
  parameter int NUM_PE       = 16,
  parameter int CFG_WIDTH    = RIPTIDE_CFG_WIDTH,
  parameter int WORDS_PER_PE = 2,
  parameter int TMO_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_PE-1:0]    active_mask,
  pe_array_seq_if.slave        host,
  output logic                 cfg_en,
  output logic [CFG_WIDTH-1:0] cfg_out,
  output logic                 ctrl_clear,
  output logic                 ctrl_en,
  input  logic [NUM_PE-1:0]    ctrl_done,
  output logic                 busy,
  output logic                 run_done,
  output logic                 err
);

  localparam int TOTAL_WORDS = NUM_PE * WORDS_PER_PE;
  localparam int CNT_W       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(TOTAL_WORDS - 1);

  seq_state_t          state, state_nxt;
  logic [CNT_W-1:0]    word_cnt;
  logic [NUM_PE-1:0]   mask_q;
  logic [NUM_PE-1:0]   done_sticky;
  logic [NUM_PE-1:0]   done_seen;
  logic                start_acc;
  logic                accept;
  logic                all_done;
  logic                tmo_exp;

  assign start_acc = (state == SEQ_IDLE) && start && !abort;
  assign done_seen = done_sticky | (ctrl_done & mask_q);
  assign all_done  = (done_seen == mask_q);
  assign busy      = (state != SEQ_IDLE);

`ifdef RIPTIDE_SEQ_TIMEOUT_EN
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = {TMO_WIDTH{1'b1}} - 1'b1;
  logic [TMO_WIDTH-1:0] tmo_cnt;

  // Watchdog: counts RUN cycles; expires on the (2**TMO_WIDTH-1)th RUN cycle.
  assign tmo_exp = (state == SEQ_RUN) && (tmo_cnt == TMO_LAST);

  // Watchdog counter and sticky error flag, error cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      tmo_cnt <= (state == SEQ_RUN) ? tmo_cnt + 1'b1 : '0;
      if (start_acc)
        err <= 1'b0;
      else if (tmo_exp && !all_done)
        err <= 1'b1;
    end
  end
`else
  assign tmo_exp = 1'b0;
  assign err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEQ_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode; abort overrides every non-IDLE transition.
  always_comb begin
    state_nxt       = state;
    ctrl_clear      = 1'b0;
    ctrl_en         = 1'b0;
    run_done        = 1'b0;
    host.host_ready = 1'b0;
    accept          = 1'b0;
    cfg_en          = 1'b0;
    cfg_out         = '0;
    case (state)
      SEQ_IDLE: begin
        if (start_acc) state_nxt = SEQ_CLEAR;
      end
      SEQ_CLEAR: begin
        ctrl_clear = 1'b1;
        state_nxt  = SEQ_LOAD;
      end
      SEQ_LOAD: begin
        host.host_ready = 1'b1;
        accept          = host.host_valid;
        cfg_en          = accept;
        cfg_out         = accept ? host.host_data : '0;
        if (accept && (word_cnt == LAST_WORD)) state_nxt = SEQ_RUN;
      end
      SEQ_RUN: begin
        ctrl_en = 1'b1;
        if (all_done)     state_nxt = SEQ_FIN;
        else if (tmo_exp) state_nxt = SEQ_ABORT;
      end
      SEQ_FIN: begin
        run_done  = 1'b1;
        state_nxt = SEQ_IDLE;
      end
      SEQ_ABORT: begin
        ctrl_clear = 1'b1;
        state_nxt  = SEQ_IDLE;
      end
      default: state_nxt = SEQ_IDLE;
    endcase
    if (abort && (state != SEQ_IDLE)) state_nxt = SEQ_ABORT;
  end

  // Word counter: advances per accepted word, restarts after the last word or on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word_cnt <= '0;
    else if (state_nxt == SEQ_ABORT || state == SEQ_IDLE)
      word_cnt <= '0;
    else if (accept)
      word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
  end

  // Completion tracking: mask captured on start, per-PE done accumulated during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      done_sticky <= '0;
    end else if (start_acc) begin
      mask_q      <= active_mask;
      done_sticky <= '0;
    end else if (state == SEQ_RUN) begin
      done_sticky <= done_seen;
    end
  end

endmodule

// File: tb/tb_pe_array_seq.sv
module tb_pe_array_seq;
  import riptide_pkg::*;

  localparam int NP = 4;
  localparam int W  = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [NP-1:0] active_mask;
  logic          cfg_en;
  logic [W-1:0]  cfg_out;
  logic          ctrl_clear;
  logic          ctrl_en;
  logic [NP-1:0] ctrl_done;
  logic          busy;
  logic          run_done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  logic [W-1:0] log_q[$];

  pe_array_seq_if #(.CFG_WIDTH(W)) bus ();

  pe_array_seq #(
    .NUM_PE(NP), .CFG_WIDTH(W), .WORDS_PER_PE(2), .TMO_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .active_mask(active_mask), .host(bus.slave), .cfg_en(cfg_en),
    .cfg_out(cfg_out), .ctrl_clear(ctrl_clear), .ctrl_en(ctrl_en),
    .ctrl_done(ctrl_done), .busy(busy), .run_done(run_done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Capture shifted words and run_done pulses mid-cycle.
  always @(negedge clk) begin
    if (cfg_en) log_q.push_back(cfg_out);
    if (run_done) rd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [NP-1:0] m);
    start = 1'b1;
    active_mask = m;
    tick();
    start = 1'b0;
  endtask

  task automatic load_words(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      bus.host_valid = 1'b1;
      bus.host_data  = base + W'(i);
      tick();
    end
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; active_mask = '0;
    ctrl_done = '0; bus.host_valid = 1'b0; bus.host_data = '0;
    #12;
    chk("rst_busy", W'(busy), 0);
    chk("rst_outs", W'({cfg_en, ctrl_clear, ctrl_en, run_done, err, bus.host_ready}), 0);
    chk("rst_cfg_out", cfg_out, 0);
    rst_n = 1'b1;
    tick();

    // 1. reset asserted mid-LOAD
    do_start(4'hF);
    tick();
    load_words(3, 32'h10);
    bus.host_valid = 1'b1;
    bus.host_data  = 32'h13;
    #1;
    chk("midload_cfg_en", W'(cfg_en), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_outs", W'({cfg_en, ctrl_clear, ctrl_en, run_done, bus.host_ready}), 0);
    chk("arst_busy", W'(busy), 0);
    chk("arst_cfg_out", cfg_out, 0);
    bus.host_valid = 1'b0;
    #15 rst_n = 1'b1;
    tick();

    // 2. full sequence, back-to-back words, staggered done pulses
    log_q.delete();
    do_start(4'hF);
    chk("t2_clear", W'(ctrl_clear), 1);
    chk("t2_busy", W'(busy), 1);
    tick();
    chk("t2_clear_once", W'(ctrl_clear), 0);
    chk("t2_ready", W'(bus.host_ready), 1);
    load_words(8, 32'hA0);
    chk("t2_run", W'(ctrl_en), 1);
    chk("t2_ready_off", W'(bus.host_ready), 0);
    chk("t2_nshift", W'(log_q.size()), 8);
    for (int i = 0; i < 8; i++) chk("t2_order", log_q[i], 32'hA0 + W'(i));
    ctrl_done = 4'h1; tick(); ctrl_done = '0; tick();
    ctrl_done = 4'h2; tick(); ctrl_done = '0; tick();
    ctrl_done = 4'h4; tick(); ctrl_done = '0; tick();
    chk("t2_wait_rd", W'(run_done), 0);
    chk("t2_wait_en", W'(ctrl_en), 1);
    ctrl_done = 4'h8; tick(); ctrl_done = '0;
    chk("t2_run_done", W'(run_done), 1);
    chk("t2_fin_en", W'(ctrl_en), 0);
    tick();
    chk("t2_idle", W'({busy, run_done}), 0);
    chk("t2_rd_cnt", W'(rd_cnt), 1);

    // 3. host_valid toggling
    log_q.delete();
    do_start(4'hF);
    tick();
    for (int i = 0; i < 15; i++) begin
      bus.host_valid = (i % 2 == 0);
      bus.host_data  = 32'h30 + W'(i);
      #1;
      chk("t3_cfg_en", W'(cfg_en), W'(i % 2 == 0));
      chk("t3_cfg_out", cfg_out, (i % 2 == 0) ? 32'h30 + W'(i) : 32'h0);
      tick();
    end
    bus.host_valid = 1'b0;
    chk("t3_run", W'(ctrl_en), 1);
    chk("t3_nshift", W'(log_q.size()), 8);
    chk("t3_last", log_q[7], 32'h3E);
    ctrl_done = 4'hF; tick(); ctrl_done = '0;
    chk("t3_run_done", W'(run_done), 1);
    tick();

    // 4. partial mask, then empty mask
    do_start(4'b0101);
    tick();
    load_words(8, 32'h50);
    ctrl_done = 4'b1010; tick(); tick();
    chk("t4_masked_ignored", W'({ctrl_en, run_done}), 2'b10);
    ctrl_done = 4'b0001; tick();
    ctrl_done = 4'b0100; tick();
    ctrl_done = '0;
    chk("t4_run_done", W'(run_done), 1);
    tick();
    do_start(4'b0000);
    tick();
    load_words(8, 32'h60);
    chk("t4z_one_run", W'({ctrl_en, run_done}), 2'b10);
    tick();
    chk("t4z_run_done", W'({ctrl_en, run_done}), 2'b01);
    tick();
    chk("t4z_rd_cnt", W'(rd_cnt), 4);

    // 5. abort in RUN, start ignored while busy
    do_start(4'hF);
    tick();
    load_words(8, 32'h70);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_start_ignored", W'({ctrl_en, ctrl_clear}), 2'b10);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_abort_en", W'(ctrl_en), 0);
    chk("t5_abort_clear", W'(ctrl_clear), 1);
    chk("t5_abort_busy", W'(busy), 1);
    tick();
    chk("t5_abort_idle", W'({busy, ctrl_clear}), 0);
    chk("t5_no_rd", W'(rd_cnt), 4);
    // abort together with start in IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("t5_abort_wins", W'(busy), 0);
    // abort during a host word: word still shifts, counter restarts
    log_q.delete();
    do_start(4'hF);
    tick();
    load_words(2, 32'h80);
    bus.host_valid = 1'b1; bus.host_data = 32'h82; abort = 1'b1;
    #1;
    chk("t5_abort_word", W'(cfg_en), 1);
    tick();
    bus.host_valid = 1'b0; abort = 1'b0;
    chk("t5_ready_drop", W'({bus.host_ready, ctrl_clear}), 2'b01);
    chk("t5_abort_nshift", W'(log_q.size()), 3);
    tick();
    do_start(4'hF);
    tick();
    load_words(7, 32'h90);
    chk("t5_still_load", W'({bus.host_ready, ctrl_en}), 2'b10);
    load_words(1, 32'h97);
    chk("t5_reload_run", W'(ctrl_en), 1);
    ctrl_done = 4'hF; tick(); ctrl_done = '0;
    chk("t5_fin", W'(run_done), 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_fin_start_ignored", W'(busy), 0);

`ifdef RIPTIDE_SEQ_TIMEOUT_EN
    // 6. watchdog expiry
    do_start(4'hF);
    tick();
    load_words(8, 32'hB0);
    for (int i = 0; i < 14; i++) tick();
    chk("t6_pre_err", W'({err, ctrl_en}), 2'b01);
    tick();
    chk("t6_err", W'(err), 1);
    chk("t6_abort_path", W'({ctrl_clear, ctrl_en, run_done}), 3'b100);
    tick();
    chk("t6_err_sticky", W'({err, busy}), 2'b10);
    do_start(4'hF);
    chk("t6_err_cleared", W'(err), 0);
    abort = 1'b1; tick(); abort = 1'b0; tick();
`else
    chk("t6_err_tied", W'(err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
